// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter that serialises reads/writes onto a byte-wide RAM command port.
// Optional read-wait watchdog enabled by defining RAM_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module ram_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] op,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rd_data,
  output logic       err,
  output logic       busy,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    R_CMD,
    R_WAIT,
    RESP
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ram_arbiter: TIMEOUT must be at least 1");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_gnt_valid;
  logic        w_gnt_idx;
  logic        w_rd_capture;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic [7:0]  r_rd_data;
  logic        r_last;
  logic        r_idx;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_timed_out;
  logic          r_err;
  logic          w_timeout;
`endif

  // NOTE: sequential state is only ever updated with <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_valid  = 1'b0;
    w_gnt_idx    = 1'b0;
    w_rd_capture = 1'b0;
    busy         = 1'b1;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) begin
          w_gnt_valid = 1'b1;
          // On a tie the requester that did not win last time goes first.
          w_gnt_idx   = (req == 2'b11) ? ~r_last : req[1];
          w_state_nxt = op[w_gnt_idx] ? R_ADDR : W_ADDR;
        end
      end
      W_ADDR: begin
        ram_din      = {2'b00, r_addr};
        ram_rx_valid = 1'b1;
        w_state_nxt  = W_DATA;
      end
      W_DATA: begin
        ram_din      = {2'b01, r_wdata};
        ram_rx_valid = 1'b1;
        w_state_nxt  = RESP;
      end
      R_ADDR: begin
        ram_din      = {2'b10, r_addr};
        ram_rx_valid = 1'b1;
        w_state_nxt  = R_CMD;
      end
      R_CMD: begin
        ram_din      = {2'b11, 8'h00};
        ram_rx_valid = 1'b1;
        w_state_nxt  = R_WAIT;
      end
      R_WAIT: begin
        if (ram_tx_valid) begin
          w_rd_capture = 1'b1;
          w_state_nxt  = RESP;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
`endif
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_rd_data <= '0;
      r_last    <= 1'b1;
      r_idx     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      if (w_gnt_valid) begin
        r_gnt[w_gnt_idx] <= 1'b1;
        r_idx            <= w_gnt_idx;
        r_last           <= w_gnt_idx;
        r_addr           <= w_gnt_idx ? addr1 : addr0;
        r_wdata          <= w_gnt_idx ? wdata1 : wdata0;
      end
      if (w_rd_capture) r_rd_data <= ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
      if (w_timeout) r_rd_data <= '0;
`endif
      // done is raised on leaving RESP, so it lands in the following IDLE cycle.
      if (r_state == RESP) r_done[r_idx] <= 1'b1;
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Counter sits at zero outside R_WAIT, which clears it on every entry.
      if (r_state == R_WAIT) r_cnt <= r_cnt + CW'(1);
      else                   r_cnt <= '0;
      if (w_gnt_valid)    r_timed_out <= 1'b0;
      else if (w_timeout) r_timed_out <= 1'b1;
      r_err <= (r_state == RESP) && r_timed_out;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, latency and RAM contents.
module tb_ram_arbiter;

  localparam int TB_TIMEOUT = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] op;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rd_data;
  logic       err;
  logic       busy;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  ram_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op           (op),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt          (gnt),
    .done         (done),
    .rd_data      (rd_data),
    .err          (err),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd  = 8'h00;
  logic       last_w  = 1'b1;
  bit         ram_en  = 1'b1;
  bit         spur    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural RAM: latches an address, writes on opcode 01, answers opcode 11 one cycle later.
  logic [7:0] ram_mem [256];
  initial begin
    logic [7:0] ram_addr;
    bit         pending;
    ram_addr     = 8'h00;
    pending      = 1'b0;
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ram_tx_valid = pending || spur;
      ram_dout     = pending ? ram_mem[ram_addr] : (spur ? 8'hFF : 8'h00);
      pending      = 1'b0;
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00, 2'b10: ram_addr = ram_din[7:0];
          2'b01:        ram_mem[ram_addr] = ram_din[7:0];
          default:      pending = ram_en;
        endcase
      end
    end
  end

  // One full transaction; the winner, command words, latency and results come from the model.
  task automatic txn(input logic [1:0] rq, input logic [1:0] o, input logic [7:0] a0,
                     input logic [7:0] a1, input logic [7:0] w0, input logic [7:0] w1,
                     input bit keep);
    int         n;
    logic       w;
    logic       rd;
    logic [7:0] a;
    logic [7:0] d;
    int         exp_lat;
    logic [7:0] exp_data;
    logic       exp_err;
    req = rq; op = o; addr0 = a0; addr1 = a1; wdata0 = w0; wdata1 = w1;
    w  = (rq == 2'b11) ? ~last_w : rq[1];
    rd = o[w];
    a  = w ? a1 : a0;
    d  = w ? w1 : w0;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
    chk("gnt_wait", n, 1);
    chk("gnt", gnt, w ? 2'b10 : 2'b01);
    chk("done_at_gnt", done, 2'b00);
    last_w = w;
    if (!keep) req = 2'b00;
    chk("cmd1", {ram_rx_valid, ram_din}, {1'b1, rd ? 2'b10 : 2'b00, a});
    @(negedge clk);
    chk("cmd2", {ram_rx_valid, ram_din}, {1'b1, rd ? 2'b11 : 2'b01, rd ? 8'h00 : d});
    n = 1;
    while (done == 2'b00 && n < 40) begin @(negedge clk); n++; end
    if (!rd) begin
      exp_lat  = 3;
      exp_data = exp_rd;
      exp_err  = 1'b0;
      ref_mem[a] = d;
    end else if (ram_en) begin
      exp_lat  = 4;
      exp_data = ref_mem[a];
      exp_err  = 1'b0;
    end else begin
      exp_lat  = TB_TIMEOUT + 3;
      exp_data = 8'h00;
      exp_err  = 1'b1;
    end
    exp_rd = exp_data;
    chk("latency", n, exp_lat);
    chk("done", done, w ? 2'b10 : 2'b01);
    chk("rd_data", rd_data, exp_data);
    chk("err", err, exp_err);
    chk("idle_outputs", {busy, ram_rx_valid, ram_din}, 12'h000);
  endtask

  initial begin
    int         n;
    logic [1:0] rq;
    rst_n = 1'b0; req = 2'b00; op = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt, done, rd_data, err, busy, ram_rx_valid, ram_din}, 25'h0);
    rst_n = 1'b1;

    // Write 0xA5 to 0x3C from requester 0, then read it back from requester 1.
    txn(2'b01, 2'b00, 8'h3C, 8'h00, 8'hA5, 8'h00, 1'b0);
    txn(2'b10, 2'b10, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0);

    // Spurious read-data strobe while idle must be ignored.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_done", done, 2'b00);
      chk("spur_rd_data", rd_data, exp_rd);
    end

    // Reset while a read is parked in R_WAIT.
    ram_en = 1'b0;
    req = 2'b10; op = 2'b10; addr1 = 8'h3C;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
    chk("stall_gnt", gnt, 2'b10);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("stall_busy", {busy, ram_rx_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_read", {gnt, done, rd_data, err, busy, ram_rx_valid, ram_din}, 25'h0);
    exp_rd = 8'h00;
    last_w = 1'b1;
    ram_en = 1'b1;
    req    = 2'b11;
    op     = 2'b00;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done, 2'b00);
    end
    rst_n = 1'b1;

    // Both requesters held from reset: grants must alternate starting with requester 0.
    for (int i = 0; i < 4; i++)
      txn(2'b11, 2'b11, 8'h3C, 8'h10 + 8'(i), 8'h00, 8'h00, 1'b1);
    req = 2'b00;

`ifdef RAM_ARB_TIMEOUT_EN
    ram_en = 1'b0;
    txn(2'b01, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0);
    ram_en = 1'b1;
`endif

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      rq = 2'($urandom_range(1, 3));
      txn(rq, 2'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
          8'($urandom), 8'($urandom), 1'($urandom));
    end
    req = 2'b00;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
